// File: rtl/leaf_user_bridge.sv
// leaf_user_bridge: per-port FWFT stream buffering and HLS kernel reset/start sequencing for a BFT leaf
// Ports (top):
//   clk, reset (async active-low)
//   li_dout/li_vld/li_ack           interface -> bridge input streams
//   k_in_data/k_in_vld/k_in_ack     bridge -> kernel input streams
//   k_out_data/k_out_vld/k_out_ack  kernel -> bridge output streams
//   li_din/li_din_vld/li_din_ack    bridge -> interface output streams
//   ap_rst, ap_start, ap_done       kernel control
//   restart                         re-run request from IDLE
//   in_word_cnt, out_word_cnt       transferred word counters
// leaf_user_bridge_fifo ports: push_i/din_i write side, pop_i/dout_o FWFT read side, full_o/empty_o status.

module leaf_user_bridge_fifo #(
    parameter int W  = 32,
    parameter int AW = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int DEPTH = 1 << AW;
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          push, pop;
    // Full comes from the registered count only, so a push into a full FIFO is refused
    // even when a pop happens in the same cycle.
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign push    = push_i && !full_o;
    assign pop     = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_q];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(push);
            rd_q  <= rd_q + AW'(pop);
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= din_i;
    end
endmodule

module leaf_user_bridge #(
    parameter int PAYLOAD_BITS    = 32,
    parameter int NUM_IN_PORTS    = 1,
    parameter int NUM_OUT_PORTS   = 1,
    parameter int FIFO_DEPTH_BITS = 2,
    parameter int RST_CYCLES      = 4,
    parameter int AUTO_RESTART    = 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    li_dout,
    input  logic [NUM_IN_PORTS-1:0]                 li_vld,
    output logic [NUM_IN_PORTS-1:0]                 li_ack,
    output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    k_in_data,
    output logic [NUM_IN_PORTS-1:0]                 k_in_vld,
    input  logic [NUM_IN_PORTS-1:0]                 k_in_ack,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   k_out_data,
    input  logic [NUM_OUT_PORTS-1:0]                k_out_vld,
    output logic [NUM_OUT_PORTS-1:0]                k_out_ack,
    output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   li_din,
    output logic [NUM_OUT_PORTS-1:0]                li_din_vld,
    input  logic [NUM_OUT_PORTS-1:0]                li_din_ack,
    output logic                                    ap_rst,
    output logic                                    ap_start,
    input  logic                                    ap_done,
    input  logic                                    restart,
    output logic [31:0]                             in_word_cnt,
    output logic [31:0]                             out_word_cnt
);
    localparam int PB  = PAYLOAD_BITS;
    localparam int RCW = RST_CYCLES > 1 ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {RST_HOLD, START, RUN, DRAIN, IDLE} state_e;

    state_e                   state_q, state_d;
    logic [RCW-1:0]           rc_q, rc_d;
    logic [31:0]              in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic [NUM_IN_PORTS-1:0]  in_full, in_empty;
    logic [NUM_OUT_PORTS-1:0] out_full, out_empty;
    logic                     if_open, k_run, k_out_open;

    assign if_open    = state_q != RST_HOLD;
    assign k_run      = state_q == RUN;
    assign k_out_open = state_q == RUN || state_q == DRAIN;

    // All handshake qualifiers derive from registered state, never from the opposite ack.
    assign li_ack     = ~in_full & {NUM_IN_PORTS{if_open}};
    assign k_in_vld   = ~in_empty & {NUM_IN_PORTS{k_run}};
    assign k_out_ack  = ~out_full & {NUM_OUT_PORTS{k_out_open}};
    assign li_din_vld = ~out_empty & {NUM_OUT_PORTS{if_open}};

    assign ap_rst       = state_q == RST_HOLD;
    assign ap_start     = state_q == START || state_q == RUN;
    assign in_word_cnt  = in_cnt_q;
    assign out_word_cnt = out_cnt_q;

    for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in
        leaf_user_bridge_fifo #(.W(PB), .AW(FIFO_DEPTH_BITS)) u_fifo (
            .clk    (clk),
            .reset  (reset),
            .push_i (li_vld[i] & li_ack[i]),
            .din_i  (li_dout[i*PB +: PB]),
            .pop_i  (k_in_vld[i] & k_in_ack[i]),
            .dout_o (k_in_data[i*PB +: PB]),
            .full_o (in_full[i]),
            .empty_o(in_empty[i])
        );
    end

    for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_out
        leaf_user_bridge_fifo #(.W(PB), .AW(FIFO_DEPTH_BITS)) u_fifo (
            .clk    (clk),
            .reset  (reset),
            .push_i (k_out_vld[j] & k_out_ack[j]),
            .din_i  (k_out_data[j*PB +: PB]),
            .pop_i  (li_din_vld[j] & li_din_ack[j]),
            .dout_o (li_din[j*PB +: PB]),
            .full_o (out_full[j]),
            .empty_o(out_empty[j])
        );
    end

    always_comb begin
        state_d = state_q;
        rc_d    = '0;
        case (state_q)
            RST_HOLD: begin
                rc_d = rc_q + RCW'(1);
                if (rc_q == RCW'(RST_CYCLES - 1)) state_d = START;
            end
            START:   state_d = RUN;
            RUN:     if (ap_done) state_d = DRAIN;
            // Drain finishes only once nothing is buffered and the kernel offers nothing more.
            DRAIN:   if (&out_empty && k_out_vld == '0) state_d = AUTO_RESTART != 0 ? START : IDLE;
            IDLE:    if (restart) state_d = RST_HOLD;
            default: state_d = RST_HOLD;
        endcase
    end

    // Entering START only happens from RST_HOLD or an empty DRAIN, where no handshake can
    // complete, so clearing on entry drops no counted words.
    always_comb begin
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        for (int i = 0; i < NUM_IN_PORTS; i++) in_cnt_d += 32'(k_in_vld[i] & k_in_ack[i]);
        for (int i = 0; i < NUM_OUT_PORTS; i++) out_cnt_d += 32'(li_din_vld[i] & li_din_ack[i]);
        if (state_d == START && state_q != START) begin
            in_cnt_d  = '0;
            out_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RST_HOLD;
            rc_q      <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rc_q      <= rc_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end
endmodule

// File: tb/tb_leaf_user_bridge.sv
// tb_leaf_user_bridge: directed checks plus a queue-based reference model for leaf_user_bridge
module tb_leaf_user_bridge;
    logic        clk = 1'b0;
    logic        reset, rb;
    int          n_chk = 0, n_fail = 0;

    // DUT A: 1 input port, 2 output ports, auto-restart
    logic [31:0] a_li_dout, a_k_in_data, a_in_cnt, a_out_cnt;
    logic [0:0]  a_li_vld, a_li_ack, a_k_in_vld, a_k_in_ack;
    logic [63:0] a_k_out_data, a_li_din;
    logic [1:0]  a_k_out_vld, a_k_out_ack, a_li_din_vld, a_li_din_ack;
    logic        a_ap_rst, a_ap_start, a_ap_done, a_restart;

    // DUT B: 1 in, 1 out, no auto-restart
    logic [31:0] b_li_dout, b_k_in_data, b_k_out_data, b_li_din, b_in_cnt, b_out_cnt;
    logic [0:0]  b_li_vld, b_li_ack, b_k_in_vld, b_k_in_ack, b_k_out_vld, b_k_out_ack, b_li_din_vld, b_li_din_ack;
    logic        b_ap_rst, b_ap_start, b_ap_done, b_restart;

    always #5 clk = ~clk;

    leaf_user_bridge #(.PAYLOAD_BITS(32), .NUM_IN_PORTS(1), .NUM_OUT_PORTS(2), .FIFO_DEPTH_BITS(2),
                       .RST_CYCLES(4), .AUTO_RESTART(1)) u_a (
        .clk(clk), .reset(reset), .li_dout(a_li_dout), .li_vld(a_li_vld), .li_ack(a_li_ack),
        .k_in_data(a_k_in_data), .k_in_vld(a_k_in_vld), .k_in_ack(a_k_in_ack),
        .k_out_data(a_k_out_data), .k_out_vld(a_k_out_vld), .k_out_ack(a_k_out_ack),
        .li_din(a_li_din), .li_din_vld(a_li_din_vld), .li_din_ack(a_li_din_ack),
        .ap_rst(a_ap_rst), .ap_start(a_ap_start), .ap_done(a_ap_done), .restart(a_restart),
        .in_word_cnt(a_in_cnt), .out_word_cnt(a_out_cnt)
    );

    leaf_user_bridge #(.PAYLOAD_BITS(32), .NUM_IN_PORTS(1), .NUM_OUT_PORTS(1), .FIFO_DEPTH_BITS(2),
                       .RST_CYCLES(4), .AUTO_RESTART(0)) u_b (
        .clk(clk), .reset(rb), .li_dout(b_li_dout), .li_vld(b_li_vld), .li_ack(b_li_ack),
        .k_in_data(b_k_in_data), .k_in_vld(b_k_in_vld), .k_in_ack(b_k_in_ack),
        .k_out_data(b_k_out_data), .k_out_vld(b_k_out_vld), .k_out_ack(b_k_out_ack),
        .li_din(b_li_din), .li_din_vld(b_li_din_vld), .li_din_ack(b_li_din_ack),
        .ap_rst(b_ap_rst), .ap_start(b_ap_start), .ap_done(b_ap_done), .restart(b_restart),
        .in_word_cnt(b_in_cnt), .out_word_cnt(b_out_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model of DUT A: phase 0=reset hold, 1=start, 2=run, 3=drain, 4=idle
    int          m_st, m_rc, m_nst;
    logic [31:0] m_qi[$], m_q0[$], m_q1[$];
    logic [31:0] m_in, m_out;
    logic        e_ack, e_kv, hs_in, pop_in, pu0, pu1, po0, po1, drained;
    logic [1:0]  e_koa, e_dv;

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            m_st = 0; m_rc = 0; m_in = 0; m_out = 0;
            m_qi.delete(); m_q0.delete(); m_q1.delete();
        end
        e_ack = m_qi.size() < 4 && m_st != 0;
        e_kv  = m_qi.size() > 0 && m_st == 2;
        e_koa = {m_q1.size() < 4 && (m_st == 2 || m_st == 3), m_q0.size() < 4 && (m_st == 2 || m_st == 3)};
        e_dv  = {m_q1.size() > 0 && m_st != 0, m_q0.size() > 0 && m_st != 0};
        chk("model_ap_rst", a_ap_rst, m_st == 0);
        chk("model_ap_start", a_ap_start, m_st == 1 || m_st == 2);
        chk("model_li_ack", a_li_ack, e_ack);
        chk("model_k_in_vld", a_k_in_vld, e_kv);
        if (e_kv) chk("model_k_in_data", a_k_in_data, m_qi[0]);
        chk("model_k_out_ack", a_k_out_ack, e_koa);
        chk("model_li_din_vld", a_li_din_vld, e_dv);
        if (e_dv[0]) chk("model_li_din0", a_li_din[31:0], m_q0[0]);
        if (e_dv[1]) chk("model_li_din1", a_li_din[63:32], m_q1[0]);
        chk("model_in_cnt", a_in_cnt, m_in);
        chk("model_out_cnt", a_out_cnt, m_out);
        if (reset) begin
            hs_in   = a_li_vld[0] && e_ack;
            pop_in  = e_kv && a_k_in_ack[0];
            pu0     = a_k_out_vld[0] && e_koa[0];
            pu1     = a_k_out_vld[1] && e_koa[1];
            po0     = e_dv[0] && a_li_din_ack[0];
            po1     = e_dv[1] && a_li_din_ack[1];
            drained = m_q0.size() == 0 && m_q1.size() == 0 && a_k_out_vld == 2'b00;
            m_in    = m_in + 32'(pop_in);
            m_out   = m_out + 32'(po0) + 32'(po1);
            if (pop_in) void'(m_qi.pop_front());
            if (hs_in) m_qi.push_back(a_li_dout);
            if (po0) void'(m_q0.pop_front());
            if (pu0) m_q0.push_back(a_k_out_data[31:0]);
            if (po1) void'(m_q1.pop_front());
            if (pu1) m_q1.push_back(a_k_out_data[63:32]);
            m_nst = m_st;
            case (m_st)
                0: begin m_rc++; if (m_rc == 4) begin m_nst = 1; m_rc = 0; end end
                1: m_nst = 2;
                2: if (a_ap_done) m_nst = 3;
                3: if (drained) m_nst = 1;
                default: if (a_restart) m_nst = 0;
            endcase
            if (m_nst == 1 && m_st != 1) begin m_in = 0; m_out = 0; end
            m_st = m_nst;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached at %0t", $time);
        $fatal(1);
    end

    initial begin
        reset = 0; rb = 0;
        a_li_dout = 0; a_li_vld = 0; a_k_in_ack = 0; a_k_out_data = 0; a_k_out_vld = 0;
        a_li_din_ack = 0; a_ap_done = 0; a_restart = 0;
        b_li_dout = 0; b_li_vld = 0; b_k_in_ack = 0; b_k_out_data = 0; b_k_out_vld = 0;
        b_li_din_ack = 0; b_ap_done = 0; b_restart = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ap_rst", a_ap_rst, 1);
        chk("reset_counters", {a_in_cnt, a_out_cnt}, 0);
        reset = 1; rb = 1;
        a_ap_done = 1;
        // Release: ap_rst for 4 cycles, ap_start in cycle 5; ap_done held high is ignored
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk($sformatf("release_ap_rst_c%0d", i), a_ap_rst, i < 5);
            chk($sformatf("release_ap_start_c%0d", i), a_ap_start, i == 5);
            chk($sformatf("release_vld_c%0d", i), {a_k_in_vld, a_li_din_vld}, 0);
        end
        tick;
        a_ap_done = 0;
        // Fill input FIFO with kernel stalled
        a_li_vld = 1;
        for (int i = 0; i < 5; i++) begin
            a_li_dout = 32'h11 * (i + 1);
            @(negedge clk);
            chk($sformatf("fill_li_ack_%0d", i), a_li_ack, i < 4);
            tick;
        end
        chk("run_after_ignored_done", a_ap_start, 1);
        a_li_vld = 0; a_k_in_ack = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("drain_vld_%0d", i), a_k_in_vld, 1);
            chk($sformatf("drain_data_%0d", i), a_k_in_data, 32'h11 * (i + 1));
            tick;
        end
        @(negedge clk);
        chk("drain_empty", a_k_in_vld, 0);
        chk("in_cnt_4", a_in_cnt, 4);
        tick;
        // Full FIFO with simultaneous push and pop
        a_k_in_ack = 0; a_li_vld = 1;
        for (int i = 0; i < 4; i++) begin
            a_li_dout = 32'hA1 + i;
            tick;
        end
        a_li_dout = 32'hA5; a_k_in_ack = 1;
        @(negedge clk);
        chk("full_push_refused", a_li_ack, 0);
        chk("full_pop_data", a_k_in_data, 32'hA1);
        tick;
        a_k_in_ack = 0;
        @(negedge clk);
        chk("retry_accepted", a_li_ack, 1);
        tick;
        a_li_vld = 0; a_k_in_ack = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("order_data_%0d", i), a_k_in_data, 32'hA2 + i);
            tick;
        end
        @(negedge clk);
        chk("in_cnt_9", a_in_cnt, 9);
        tick;
        a_k_in_ack = 0;
        // Output ports: port 1 stalled, then ap_done into DRAIN
        a_li_din_ack = 2'b01;
        a_k_out_vld = 2'b11; a_k_out_data = {32'hB1, 32'hC1};
        @(negedge clk);
        chk("k_out_ack_run", a_k_out_ack, 2'b11);
        tick;
        a_k_out_vld = 2'b10; a_k_out_data = {32'hB2, 32'h0};
        tick;
        a_k_out_data = {32'hB3, 32'h0};
        tick;
        a_k_out_vld = 0; a_ap_done = 1;
        tick;
        a_ap_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("drain_hold_start_%0d", i), a_ap_start, 0);
            chk($sformatf("drain_hold_vld_%0d", i), a_li_din_vld, 2'b10);
            tick;
        end
        a_li_din_ack = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("drain_out_data_%0d", i), a_li_din[63:32], 32'hB1 + i);
            tick;
        end
        @(negedge clk);
        chk("drain_done_vld", a_li_din_vld, 0);
        chk("out_cnt_4", a_out_cnt, 4);
        chk("drain_done_start", a_ap_start, 0);
        @(negedge clk);
        chk("auto_restart_start", a_ap_start, 1);
        chk("restart_cnt_clear", {a_in_cnt, a_out_cnt}, 0);
        tick;
        a_li_din_ack = 0;
        // Reset in RUN with two buffered words
        a_li_vld = 1; a_li_dout = 32'hD1;
        tick;
        a_li_dout = 32'hD2;
        tick;
        a_li_vld = 0;
        chk("pre_reset_buffered", a_k_in_vld, 1);
        #2;
        reset = 0;
        #1;
        chk("async_reset_ap_rst", a_ap_rst, 1);
        chk("async_reset_ap_start", a_ap_start, 0);
        chk("async_reset_vld", {a_li_ack, a_k_in_vld, a_k_out_ack, a_li_din_vld}, 0);
        @(posedge clk);
        #1;
        reset = 1;
        a_k_in_ack = 1;
        repeat (5) @(negedge clk);
        chk("post_reset_start", a_ap_start, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("no_stale_word_%0d", i), a_k_in_vld, 0);
        end
        tick;
        a_k_in_ack = 0;
        // DUT B: drain into IDLE, then restart
        b_k_out_vld = 1; b_k_out_data = 32'hE1;
        @(negedge clk);
        chk("b_k_out_ack_run", b_k_out_ack, 1);
        tick;
        b_k_out_vld = 0; b_ap_done = 1;
        tick;
        b_ap_done = 0;
        @(negedge clk);
        chk("b_drain_start", b_ap_start, 0);
        chk("b_drain_vld", b_li_din_vld, 1);
        chk("b_drain_data", b_li_din, 32'hE1);
        tick;
        b_li_din_ack = 1;
        @(negedge clk);
        tick;
        @(negedge clk);
        chk("b_drain_empty", b_li_din_vld, 0);
        chk("b_out_cnt", b_out_cnt, 1);
        tick;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("b_idle_start_%0d", i), b_ap_start, 0);
            chk($sformatf("b_idle_rst_%0d", i), b_ap_rst, 0);
            chk($sformatf("b_idle_k_out_ack_%0d", i), b_k_out_ack, 0);
            tick;
        end
        b_restart = 1;
        tick;
        b_restart = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk($sformatf("b_restart_ap_rst_c%0d", i), b_ap_rst, i < 5);
            chk($sformatf("b_restart_ap_start_c%0d", i), b_ap_start, i == 5);
        end
        chk("b_restart_cnt_clear", b_out_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
